ps2_host_tx: RTL

- Host-to-device PS/2 transmitter; the send path complementing the existing keyboard receive path.
- Issues one-byte commands to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset): request-to-send, serialised frame, device ACK check.
- Sits beside the keyboard receiver on the shared PS2_CLK/PS2_DATA pins. The top level builds the open-drain tristate from this block's output-enables.

---
 rtl/ps2_host_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device: request-to-send, a frame of eleven
// device-clocked bits, then the device ACK check. Drives only the
// output-enables; the top level builds the open-drain pads.
// Optional build macro PS2_TX_GLITCH_FILTER_EN adds an 8-sample stability
// filter on the synchronised PS/2 clock.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_XFER      = 3'd2;
    localparam logic [2:0] S_ACK       = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_ERR       = 3'd6;

    logic clk_s1, clk_s2, dat_s1, dat_s2;
    logic clk_cond, clk_prev, clk_fall;

    logic [2:0]    state, state_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          par_q, par_nxt;
    logic [3:0]    bit_cnt, bit_nxt;
    logic [IW-1:0] inh_cnt, inh_nxt, inh_inc;
    logic [TW-1:0] tmo_cnt, tmo_nxt, tmo_inc;
    logic          ready_nxt, done_nxt, err_nxt, clk_oe_nxt, data_oe_nxt;

    // Two-flop synchronisers; lines idle high so reset to 1 to avoid a false edge
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data_in;
            dat_s2 <= dat_s1;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic       clk_filt;
    logic [2:0] filt_cnt;

    // Filtered level follows the synced clock only after 8 identical samples
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= 3'd0;
        end else if (clk_s2 == clk_filt) begin
            filt_cnt <= 3'd0;
        end else if (filt_cnt == 3'd7) begin
            clk_filt <= clk_s2;
            filt_cnt <= 3'd0;
        end else begin
            filt_cnt <= filt_cnt + 3'd1;
        end
    end

    assign clk_cond = clk_filt;
`else
    assign clk_cond = clk_s2;
`endif

    // Previous conditioned clock level for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) clk_prev <= 1'b1;
        else     clk_prev <= clk_cond;
    end

    assign clk_fall = clk_prev & ~clk_cond;
    assign inh_inc  = inh_cnt + IW'(1);
    assign tmo_inc  = tmo_cnt + TW'(1);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            data_q      <= 8'd0;
            par_q       <= 1'b0;
            bit_cnt     <= 4'd0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            state       <= state_nxt;
            data_q      <= data_nxt;
            par_q       <= par_nxt;
            bit_cnt     <= bit_nxt;
            inh_cnt     <= inh_nxt;
            tmo_cnt     <= tmo_nxt;
            tx_ready    <= ready_nxt;
            tx_done     <= done_nxt;
            tx_err      <= err_nxt;
            ps2_clk_oe  <= clk_oe_nxt;
            ps2_data_oe <= data_oe_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        data_nxt    = data_q;
        par_nxt     = par_q;
        bit_nxt     = bit_cnt;
        inh_nxt     = inh_cnt;
        tmo_nxt     = '0;
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = ps2_data_oe;

        case (state)
            S_IDLE: begin
                data_oe_nxt = 1'b0;
                bit_nxt     = 4'd0;
                inh_nxt     = '0;
                if (tx_valid && tx_ready) begin
                    data_nxt    = tx_data;
                    par_nxt     = ~^tx_data;
                    state_nxt   = S_INHIBIT;
                    clk_oe_nxt  = 1'b1;
                    data_oe_nxt = (INHIBIT_CYCLES == 1);
                end
            end
            S_INHIBIT: begin
                if (inh_cnt == INH_LAST) begin
                    state_nxt   = S_XFER;
                    data_oe_nxt = 1'b1;
                end else begin
                    clk_oe_nxt  = 1'b1;
                    inh_nxt     = inh_inc;
                    data_oe_nxt = (inh_inc == INH_LAST);
                end
            end
            S_XFER: begin
                tmo_nxt = tmo_inc;
                if (tmo_inc == TMO_MAX) begin
                    state_nxt = S_ERR;
                end else if (clk_fall) begin
                    bit_nxt = bit_cnt + 4'd1;
                    if (bit_cnt < 4'd8) begin
                        data_oe_nxt = ~data_q[bit_cnt[2:0]];
                    end else if (bit_cnt == 4'd8) begin
                        data_oe_nxt = ~par_q;
                    end else begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                tmo_nxt = tmo_inc;
                if (tmo_inc == TMO_MAX) begin
                    state_nxt = S_ERR;
                end else if (clk_fall) begin
                    state_nxt = dat_s2 ? S_ERR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                tmo_nxt = tmo_inc;
                if (tmo_inc == TMO_MAX) begin
                    state_nxt = S_ERR;
                end else if (clk_cond && dat_s2) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Error always releases the data line; pulses and ready follow the next state
        if (state_nxt == S_ERR) data_oe_nxt = 1'b0;
        ready_nxt = (state_nxt == S_IDLE);
        done_nxt  = (state_nxt == S_DONE);
        err_nxt   = (state_nxt == S_ERR);
    end

endmodule
